// File: rtl/reservation_station_if.sv
// Dispatch/CDB/issue bundle for one reservation station.
// Latency: none (wires only).
// Backpressure: rs_is_full stalls dispatch; fu_ready stalls issue.
interface reservation_station_if #(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 3,
  parameter int FUNC_W = 4
);
  logic              rs_load;
  logic [FUNC_W-1:0] in_func;
  logic [TAG_W-1:0]  in_tag_dest;
  logic              in_ready_src1;
  logic              in_ready_src2;
  logic [XLEN-1:0]   in_value_src1;
  logic [XLEN-1:0]   in_value_src2;
  logic [TAG_W-1:0]  in_tag_src1;
  logic [TAG_W-1:0]  in_tag_src2;
  logic [XLEN-1:0]   in_imm;
  logic [XLEN-1:0]   in_pc;
  logic              rs_is_full;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [XLEN-1:0]   cdb_value;
  logic              squash;
  logic              issue_valid;
  logic              fu_ready;
  logic [FUNC_W-1:0] issue_func;
  logic [TAG_W-1:0]  issue_tag_dest;
  logic [XLEN-1:0]   issue_src1;
  logic [XLEN-1:0]   issue_src2;
  logic [XLEN-1:0]   issue_imm;
  logic [XLEN-1:0]   issue_pc;

  modport master (
    output rs_load, in_func, in_tag_dest, in_ready_src1, in_ready_src2,
           in_value_src1, in_value_src2, in_tag_src1, in_tag_src2, in_imm, in_pc,
           cdb_valid, cdb_tag, cdb_value, squash, fu_ready,
    input  rs_is_full, issue_valid, issue_func, issue_tag_dest,
           issue_src1, issue_src2, issue_imm, issue_pc
  );

  modport slave (
    input  rs_load, in_func, in_tag_dest, in_ready_src1, in_ready_src2,
           in_value_src1, in_value_src2, in_tag_src1, in_tag_src2, in_imm, in_pc,
           cdb_valid, cdb_tag, cdb_value, squash, fu_ready,
    output rs_is_full, issue_valid, issue_func, issue_tag_dest,
           issue_src1, issue_src2, issue_imm, issue_pc
  );
endinterface

// File: rtl/reservation_station.sv
// Tomasulo reservation station: holds renamed ops, snoops the CDB, issues oldest ready op.
// Latency: load-to-issue 1 cycle; CDB wakeup-to-issue 1 cycle (0 with RS_CDB_BYPASS_EN).
// Backpressure: rs_is_full from registered state stalls dispatch; issue_* hold while !fu_ready.
module reservation_station #(
  parameter int RS_DEPTH = 4,
  parameter int XLEN     = 32,
  parameter int TAG_W    = 3,
  parameter int FUNC_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reservation_station_if.slave bus
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int AGE_W = IDX_W + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  typedef struct packed {
    logic             rdy;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  value;
  } src_t;

  typedef struct packed {
    logic              valid;
    logic [FUNC_W-1:0] func;
    logic [TAG_W-1:0]  tag_dest;
    src_t              src1;
    src_t              src2;
    logic [XLEN-1:0]   imm;
    logic [XLEN-1:0]   pc;
    logic [AGE_W-1:0]  age;
  } entry_t;

  entry_t              ent_q [RS_DEPTH];
  logic [RS_DEPTH-1:0] wake1, wake2, cand;
  logic                full;
  logic [IDX_W-1:0]    free_idx;
  logic                sel_found;
  logic [IDX_W-1:0]    sel_idx;
  logic [AGE_W-1:0]    sel_age;
  logic                fire;
  src_t                new_src1, new_src2;

  // Per-entry CDB tag match on pending sources, and issue eligibility
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    cand  = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      wake1[i] = bus.cdb_valid && ent_q[i].valid && !ent_q[i].src1.rdy &&
                 (ent_q[i].src1.tag == bus.cdb_tag);
      wake2[i] = bus.cdb_valid && ent_q[i].valid && !ent_q[i].src2.rdy &&
                 (ent_q[i].src2.tag == bus.cdb_tag);
`ifdef RS_CDB_BYPASS_EN
      cand[i] = ent_q[i].valid && (ent_q[i].src1.rdy || wake1[i]) &&
                (ent_q[i].src2.rdy || wake2[i]);
`else
      cand[i] = ent_q[i].valid && ent_q[i].src1.rdy && ent_q[i].src2.rdy;
`endif
    end
  end

  // Full flag and lowest-index free slot, from registered state only
  always_comb begin
    full     = 1'b1;
    free_idx = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        full     = 1'b0;
        free_idx = IDX_W'(i);
      end
    end
  end

  // Oldest candidate wins; strict compare keeps the lowest index on ties
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cand[i] && (!sel_found || ent_q[i].age > sel_age)) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = ent_q[i].age;
      end
    end
  end

  // Issue bus carries the selected entry, all zeros when nothing is offered
  always_comb begin
    bus.rs_is_full     = full;
    bus.issue_valid    = sel_found;
    bus.issue_func     = '0;
    bus.issue_tag_dest = '0;
    bus.issue_src1     = '0;
    bus.issue_src2     = '0;
    bus.issue_imm      = '0;
    bus.issue_pc       = '0;
    if (sel_found) begin
      bus.issue_func     = ent_q[sel_idx].func;
      bus.issue_tag_dest = ent_q[sel_idx].tag_dest;
      bus.issue_src1     = ent_q[sel_idx].src1.value;
      bus.issue_src2     = ent_q[sel_idx].src2.value;
      bus.issue_imm      = ent_q[sel_idx].imm;
      bus.issue_pc       = ent_q[sel_idx].pc;
`ifdef RS_CDB_BYPASS_EN
      if (!ent_q[sel_idx].src1.rdy) bus.issue_src1 = bus.cdb_value;
      if (!ent_q[sel_idx].src2.rdy) bus.issue_src2 = bus.cdb_value;
`endif
    end
  end

  assign fire = sel_found && bus.fu_ready;

  // Incoming operands, captured from the CDB if it broadcasts their producer now
  always_comb begin
    new_src1 = '{rdy: bus.in_ready_src1, tag: bus.in_tag_src1, value: bus.in_value_src1};
    new_src2 = '{rdy: bus.in_ready_src2, tag: bus.in_tag_src2, value: bus.in_value_src2};
    if (bus.cdb_valid && !bus.in_ready_src1 && bus.in_tag_src1 == bus.cdb_tag) begin
      new_src1.rdy   = 1'b1;
      new_src1.value = bus.cdb_value;
    end
    if (bus.cdb_valid && !bus.in_ready_src2 && bus.in_tag_src2 == bus.cdb_tag) begin
      new_src2.rdy   = 1'b1;
      new_src2.value = bus.cdb_value;
    end
  end

  // Entry update: reset/squash clear all; else issue frees, snoop wakes, ages advance, load fills
  always_ff @(posedge clk) begin
    if (reset || bus.squash) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (fire && sel_idx == IDX_W'(i)) begin
          ent_q[i].valid <= 1'b0;
        end else if (ent_q[i].valid) begin
          if (wake1[i]) begin
            ent_q[i].src1.rdy   <= 1'b1;
            ent_q[i].src1.value <= bus.cdb_value;
          end
          if (wake2[i]) begin
            ent_q[i].src2.rdy   <= 1'b1;
            ent_q[i].src2.value <= bus.cdb_value;
          end
          if (ent_q[i].age != AGE_MAX) ent_q[i].age <= ent_q[i].age + 1'b1;
        end else if (bus.rs_load && !full && free_idx == IDX_W'(i)) begin
          ent_q[i] <= '{valid: 1'b1, func: bus.in_func, tag_dest: bus.in_tag_dest,
                        src1: new_src1, src2: new_src2, imm: bus.in_imm,
                        pc: bus.in_pc, age: '0};
        end
      end
    end
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
- One per functional unit in the Tomasulo core; this is the receiving end of the dispatch-to-RS interface.
- Accepts one renamed instruction per cycle from dispatch (`rs_load`, instruction fields) and reports `rs_is_full` back so dispatch can stall.
- Holds up to RS_DEPTH entries, snoops the CDB to capture pending source operands, and issues the oldest fully-ready entry to its functional unit under a valid/ready handshake.

Parameters:
- RS_DEPTH, 4: number of entries, power of two, ≥2.
- XLEN, 32: operand/data width.
- TAG_W, 3: ROB tag width.
- FUNC_W, 4: opaque function-select width, passed through unchanged.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- rs_load  in  1  dispatch writes one instruction this cycle.
- in_func  in  FUNC_W  function select.
- in_tag_dest  in  TAG_W  ROB tag of result.
- in_ready_src1 / in_ready_src2  in  1 each  operand already valid.
- in_value_src1 / in_value_src2  in  XLEN each  operand value; meaningful only when the matching ready bit is 1.
- in_tag_src1 / in_tag_src2  in  TAG_W each  producer tag; meaningful only when the matching ready bit is 0.
- in_imm, in_pc  in  XLEN each  passed through unchanged.
- rs_is_full  out  1  no free entry.
- cdb_valid  in  1  broadcast valid.
- cdb_tag  in  TAG_W  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- squash  in  1  flush all entries (branch mispredict).
- issue_valid  out  1  an entry is offered to the FU.
- fu_ready  in  1  FU accepts this cycle.
- issue_func, issue_tag_dest, issue_src1, issue_src2, issue_imm, issue_pc  out  FUNC_W / TAG_W / XLEN / XLEN / XLEN / XLEN  issued entry contents.

Behaviour:
- Entry state: valid, func, tag_dest, {rdy, tag, value} ×2, imm, pc, age (log2(RS_DEPTH)+1 bits, saturating).
- Reset: all valid=0 and ages=0. Outputs: rs_is_full=0, issue_valid=0, all issue_* = 0.
- rs_is_full = all entries valid. It is derived only from registered state, never from this cycle's issue.
- Allocation:
  - Occurs on the rising edge when rs_load=1 and rs_is_full=0.
  - Writes the lowest-index free entry and sets age=0.
  - rs_load while rs_is_full=1 is ignored; contents are unchanged.
- Allocation-time wakeup: if cdb_valid, an incoming source with ready=0 and tag==cdb_tag is stored with rdy=1 and value=cdb_value.
- CDB snoop: each cycle, for every valid entry and each source with rdy=0 and tag==cdb_tag while cdb_valid, set rdy=1 and value=cdb_value on the edge.
- Issue select (combinational from registered state):
  - Candidates are entries with valid && rdy1 && rdy2.
  - Pick the maximum age; on a tie, pick the lowest index.
  - issue_valid=1 if any candidate exists; issue_* carry that entry. When issue_valid=0, issue_* = 0.
- Issue handshake:
  - When issue_valid && fu_ready, the selected entry's valid is cleared on the edge.
  - issue_* must hold stable while issue_valid && !fu_ready, unless an older entry becomes ready.
- Aging: each edge, every valid entry not freed increments age, saturating at max.
- Latency: an instruction loaded with both operands ready at edge N can issue in cycle N+1. An operand woken by the CDB at edge N is issuable in cycle N+1.
- Simultaneous events:
  - Issue and load in the same cycle when not full: both occur; the load uses a different free slot.
  - When full, a same-cycle issue does not admit the load; rs_is_full drops in the next cycle.
- squash: all valid=0 on the edge. It overrides load and issue in that cycle, and issue_valid=0 in the next cycle. Reset mid-operation behaves identically.
- Tags are never compared on invalid entries or on ready sources.

Optional Feature:
- Macro: RS_CDB_BYPASS_EN.
- When defined: an entry whose only missing operand(s) match the current cdb_tag is an issue candidate in the same cycle. The operand value is forwarded from cdb_value to issue_src1/issue_src2, saving one cycle.
- When undefined: the wakeup takes effect the next cycle, as specified above. issue_* then depend only on registered state.

Test Plan:
1. Reset, then load func=3, src1=5, src2=7 (both ready) with fu_ready=1 -> issue_valid=1 next cycle with issue_src1=5, issue_src2=7; entry freed; rs_is_full stays 0.
2. Load 4 entries with fu_ready=0 -> rs_is_full=1 after the 4th edge. A 5th load (tag_dest=6) is dropped. After one issue, rs_is_full=0 the following cycle.
3. Load entry with src1 waiting on tag 2; next cycle drive cdb_valid, cdb_tag=2, cdb_value=0xDEAD -> issue_src1=0xDEAD; issue_valid in the cycle after (bypass off) or the same cycle (bypass on).
4. Load with src2 waiting on tag 4 in the same cycle cdb broadcasts tag 4, value 0x10 -> entry stored ready; issue_src2=0x10 next cycle.
5. Load entries A (ready), then B (ready) with fu_ready=0 for 2 cycles -> A issues first when fu_ready=1, then B; issue_* stable while stalled.
6. Three entries valid, assert squash together with rs_load -> all entries cleared, load dropped, issue_valid=0 and rs_is_full=0 next cycle.
